// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: ALU control extension codes and FSM state encoding.
package div_unit_pkg;

   localparam int unsigned ALU_CTRL_W = 4;

   // ALUCtrl extension codes routed to the divider instead of the ALU
   localparam logic [ALU_CTRL_W-1:0] ALU_DIV  = 4'b1100;
   localparam logic [ALU_CTRL_W-1:0] ALU_DIVU = 4'b1101;
   localparam logic [ALU_CTRL_W-1:0] ALU_REM  = 4'b1110;
   localparam logic [ALU_CTRL_W-1:0] ALU_REMU = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } div_state_e;

   // Decode helpers for EX-stage control
   function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] ctrl);
      return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU) || (ctrl == ALU_REM) || (ctrl == ALU_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [ALU_CTRL_W-1:0] ctrl);
      return (ctrl == ALU_DIV) || (ctrl == ALU_REM);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] trial;

   // Extra guard bit keeps the sign of the trial valid even for divisors with the MSB set
   always_comb begin
      rem_sh = {rem_i, quo_i[WIDTH-1]};
      trial  = {1'b0, rem_sh} - {2'b00, divisor_i};
      if (!trial[WIDTH+1]) begin
         rem_o = WIDTH'(trial);
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = WIDTH'(rem_sh);
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative multi-cycle divider with RISC-V DIV/DIVU/REM/REMU semantics and start/busy/done handshake.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] step_rem, step_quo;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dmag_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // Operand magnitudes for the unsigned core
   always_comb begin
      a_neg = signed_i & dividend_i[WIDTH-1];
      b_neg = signed_i & divisor_i[WIDTH-1];
      a_mag = a_neg ? (~dividend_i + 1'b1) : dividend_i;
      b_mag = b_neg ? (~divisor_i + 1'b1) : divisor_i;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dmag_d      = dmag_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start_i) begin
               if (divisor_i == '0) begin
                  quotient_d  = '1;
                  remainder_d = dividend_i;
                  state_d     = ST_DONE;
               end else if (signed_i && (dividend_i == INT_MIN) && (divisor_i == '1)) begin
                  quotient_d  = dividend_i;
                  remainder_d = '0;
                  state_d     = ST_DONE;
               end else begin
                  rem_d     = '0;
                  quo_d     = a_mag;
                  dmag_d    = b_mag;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = '0;
                  state_d   = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            // Final iteration: sign fix-up lands on the outputs as DONE is entered
            if (cnt_q == CNT_LAST) begin
               quotient_d  = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
               remainder_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
               state_d     = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_CALC);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dmag_q      <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dmag_q      <= dmag_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32) using hand-computed quotient/remainder vectors.
module tb_div_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        signed_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] quotient_o;
   logic [31:0] remainder_o;

   int checks   = 0;
   int failures = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .signed_i    (signed_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int busy_cyc, output bit seen);
      busy_cyc = 0;
      seen     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy_o === 1'b1) busy_cyc++;
         tick();
      end
   endtask

   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output bit seen);
      signed_i   = s;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(busy_cyc, seen);
   endtask

   task automatic expect_op(input string tag, input logic s, input logic [31:0] a,
                            input logic [31:0] b, input int exp_busy,
                            input logic [31:0] exp_q, input logic [31:0] exp_r);
      int bc;
      bit seen;
      run_op(s, a, b, bc, seen);
      check({tag, "_done"}, 32'(seen), 32'd1);
      check({tag, "_busy"}, 32'(bc), 32'(exp_busy));
      check({tag, "_q"}, quotient_o, exp_q);
      check({tag, "_r"}, remainder_o, exp_r);
   endtask

   initial begin
      int  bc;
      int  dones;
      bit  seen;

      rst_i      = 1'b0;
      start_i    = 1'b0;
      signed_i   = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_q", quotient_o, 32'd0);
      check("rst_r", remainder_o, 32'd0);
      rst_i = 1'b1;
      tick();

      // Unsigned 100/7, then single-cycle done pulse with held results
      expect_op("u100_7", 1'b0, 32'd100, 32'd7, 32, 32'd14, 32'd2);
      tick();
      check("done_pulse", 32'(done_o), 32'd0);
      check("hold_q", quotient_o, 32'd14);
      check("hold_r", remainder_o, 32'd2);

      // Signed rounding toward zero, remainder follows dividend sign
      expect_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      expect_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32, 32'hFFFF_FFFD, 32'd1);
      expect_op("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32, 32'd3, 32'hFFFF_FFFF);
      expect_op("u_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32, 32'h7FFF_FFFC, 32'd1);
      expect_op("u_msb_div", 1'b0, 32'hFFFF_FFFE, 32'h8000_0001, 32, 32'd1, 32'h7FFF_FFFD);

      // Special cases bypass the iteration
      expect_op("s_div0", 1'b1, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5);
      expect_op("u_div0", 1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5);
      expect_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0);
      expect_op("u_noovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0, 32'h8000_0000);

      // start while busy is ignored
      tick();
      signed_i   = 1'b0;
      dividend_i = 32'd12345;
      divisor_i  = 32'd10;
      start_i    = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("c10_busy", 32'(busy_o), 32'd1);
      dividend_i = 32'd1000;
      divisor_i  = 32'd3;
      start_i    = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(bc, seen);
      check("ign_done", 32'(seen), 32'd1);
      check("ign_busy_rest", 32'(bc), 32'd22);
      check("ign_q", quotient_o, 32'd1234);
      check("ign_r", remainder_o, 32'd5);

      // Back-to-back start accepted on the done cycle
      expect_op("b2b", 1'b0, 32'd1000, 32'd10, 32, 32'd100, 32'd0);

      // Reset mid-calculation discards the operation
      tick();
      signed_i   = 1'b0;
      dividend_i = 32'd100;
      divisor_i  = 32'd7;
      start_i    = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      check("c15_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_q", quotient_o, 32'd0);
      check("abort_r", remainder_o, 32'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o === 1'b1 || busy_o === 1'b1) dones++;
         tick();
      end
      check("abort_quiet", 32'(dones), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
